formula_requester: RTL
======================

Name: formula_requester

Overview:
- Initiator side of the start/ack compute handshake used by the formula engine. Sequences a batch of jobs through one engine: drives n, pulses start, waits for ack, captures sum.
- Results go into a small indexed result buffer with a running total. The host reads them back after a one-cycle done pulse.
- Sits between host control logic and one formula engine instance.

Parameters:
- W, 16, data width of n, sum, results and total.
- DEPTH, 8, result buffer entries; max jobs per batch (power of 2).
- TIMEOUT, 64, cycles to wait for ack before aborting (used only with the optional feature).

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  synchronous, active-high reset.
- go  in  1  host batch request; sampled only in IDLE.
- n_first  in  W  first n of the batch; captured on accepted go.
- n_count  in  $clog2(DEPTH)+1  number of jobs; captured on accepted go.
- busy  out  1  high from accepted go until DONE exits.
- done  out  1  one-cycle pulse at batch end.
- err  out  1  sticky timeout flag; cleared by the next accepted go.
- total  out  W  sum of all captured results mod 2^W.
- rd_addr  in  $clog2(DEPTH)  result index to read.
- rd_data  out  W  buffer[rd_addr], registered, 1-cycle latency.
- req_start  out  1  start to the engine.
- req_n  out  W  n to the engine; stable from ISSUE through capture.
- eng_sum  in  W  engine result.
- eng_ack  in  1  engine ack. Level-style: stays high after a job until the engine accepts the next start.

Behaviour:
- Reset values: busy, done, err, req_start = 0; total, req_n, rd_data = 0; state = IDLE; ack_q = 0. Buffer contents are not cleared.
- IDLE:
  - go=1 captures n_first into req_n and cnt = min(n_count, DEPTH), clears idx, total and err, and sets busy.
  - Next state is ISSUE if cnt>0, else DONE.
- ISSUE: req_start=1 for exactly one cycle; then WAIT_ACK.
- WAIT_ACK:
  - ack_q registers eng_ack every cycle.
  - A job completes only on a rising edge (eng_ack=1 and ack_q=0). A stale high ack from the previous job is ignored until it has dropped.
  - On the edge: buffer[idx] <= eng_sum and total <= total + eng_sum (wraps mod 2^W); then STORE.
- STORE:
  - idx <= idx+1, req_n <= req_n+1 (wraps mod 2^W), cnt <= cnt-1.
  - Next state is ISSUE if cnt>1, else DONE.
- DONE: done=1 for one cycle, busy<=0, back to IDLE.
- Latency: per job = 1 (ISSUE) + engine time + 1 (STORE). Batch end adds 1 cycle for DONE.
- go while busy is ignored (no queuing). go held high re-triggers a new batch on the first IDLE cycle after DONE.
- Rst mid-batch forces IDLE immediately and drops req_start the same edge. Partial results stay in the buffer; total reads 0.
- rd_data is valid at any time, including during a batch. A read of an entry written in the same cycle returns the old value.

Optional Feature:
- Macro FORMULA_REQ_TIMEOUT_EN.
- Defined: a W-bit watchdog counts WAIT_ACK cycles.
  - On reaching TIMEOUT with no ack edge: err<=1, the remaining jobs are abandoned, go to DONE.
  - If an ack edge and expiry occur in the same cycle, the ack wins.
- Undefined: no counter; WAIT_ACK waits forever; err is tied to 0.

Decomposition:
- Shared package: state encoding constants (IDLE, ISSUE, WAIT_ACK, STORE, DONE), default W/DEPTH/TIMEOUT.
- One sub-module: formula_result_buf, a DEPTH x W single write port / registered read port memory.

Test Plan:
- Engine model sum=7n+21. go, n_first=1, n_count=3 -> req_n 1,2,3; buffer {28,35,42}; total=105; one done pulse; err=0.
- n_count=0 -> no req_start; done pulses 2 cycles after go; total=0.
- n_count=12, DEPTH=8 -> exactly 8 jobs. n_first=0xFFFE -> req_n wraps 0xFFFE, 0xFFFF, 0x0000, ...
- Engine holds ack high from the prior job for 3 cycles after start -> no capture until a fresh rising edge; correct sum stored.
- Rst asserted during WAIT_ACK of job 2 -> next cycle IDLE, busy=0, req_start=0, total=0; a new batch then runs cleanly.
- With FORMULA_REQ_TIMEOUT_EN: engine never acks, TIMEOUT=64 -> err=1 and done 64 cycles into WAIT_ACK. The next go clears err.

Source files
------------

// File: rtl/formula_requester_pkg.sv
// rtl/formula_requester_pkg.sv - shared state encoding and default sizing for the formula requester
package formula_requester_pkg;
   localparam int W_DEF       = 16;
   localparam int DEPTH_DEF   = 8;
   localparam int TIMEOUT_DEF = 64;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ISSUE    = 3'd1;
   localparam logic [2:0] S_WAIT_ACK = 3'd2;
   localparam logic [2:0] S_STORE    = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;
endpackage

// File: rtl/formula_result_buf.sv
// rtl/formula_result_buf.sv - DEPTH x W result memory, one write port, registered read port
module formula_result_buf
   import formula_requester_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [W-1:0]             rd_data
);
   logic [W-1:0] mem [DEPTH];

   // Contents survive reset; only the read register is cleared.
   always_ff @(posedge Clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge Clk) begin
      if (Rst) rd_data <= '0;
      else     rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/formula_requester.sv
// rtl/formula_requester.sv - batch initiator for the formula engine start/ack handshake
// Optional ack watchdog enabled by defining FORMULA_REQ_TIMEOUT_EN.
module formula_requester
   import formula_requester_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     go,
   input  logic [W-1:0]             n_first,
   input  logic [$clog2(DEPTH):0]   n_count,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [W-1:0]             total,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [W-1:0]             rd_data,
   output logic                     req_start,
   output logic [W-1:0]             req_n,
   input  logic [W-1:0]             eng_sum,
   input  logic                     eng_ack
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_cap;
   logic [AW-1:0] idx;
   logic          ack_q;
   logic          ack_edge;
   logic          buf_we;
   logic          expired;

   // Ack is level-style, so only a fresh rise marks a new result.
   assign ack_edge  = eng_ack & ~ack_q;
   assign buf_we    = (state == S_WAIT_ACK) && ack_edge;
   assign req_start = (state == S_ISSUE);
   assign cnt_cap   = (n_count > CW'(DEPTH)) ? CW'(DEPTH) : n_count;

`ifdef FORMULA_REQ_TIMEOUT_EN
   logic [W-1:0] wd;

   // An ack edge in the expiry cycle still completes the job.
   assign expired = (state == S_WAIT_ACK) && (wd == W'(TIMEOUT - 1)) && !ack_edge;

   always_ff @(posedge Clk) begin
      if (Rst)                         wd <= '0;
      else if (state == S_WAIT_ACK)    wd <= wd + W'(1);
      else                             wd <= '0;
   end

   always_ff @(posedge Clk) begin
      if (Rst)                         err <= 1'b0;
      else if (state == S_IDLE && go)  err <= 1'b0;
      else if (expired)                err <= 1'b1;
   end
`else
   assign expired = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         total <= '0;
         req_n <= '0;
         ack_q <= 1'b0;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         ack_q <= eng_ack;
         done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (go) begin
                  req_n <= n_first;
                  cnt   <= cnt_cap;
                  idx   <= '0;
                  total <= '0;
                  busy  <= 1'b1;
                  state <= (cnt_cap != '0) ? S_ISSUE : S_DONE;
               end
            end
            S_ISSUE: state <= S_WAIT_ACK;
            S_WAIT_ACK: begin
               if (ack_edge) begin
                  total <= total + eng_sum;
                  state <= S_STORE;
               end else if (expired) begin
                  state <= S_DONE;
               end
            end
            S_STORE: begin
               idx   <= idx + AW'(1);
               req_n <= req_n + W'(1);
               cnt   <= cnt - CW'(1);
               state <= (cnt > CW'(1)) ? S_ISSUE : S_DONE;
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   formula_result_buf #(.W(W), .DEPTH(DEPTH)) u_buf (
      .Clk     (Clk),
      .Rst     (Rst),
      .we      (buf_we),
      .waddr   (idx),
      .wdata   (eng_sum),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );
endmodule
